// File: rtl/riscv_irq_pkg.sv
// Shared types and constants for the RISC-V interrupt arbiter.
package riscv_irq_pkg;

    localparam int IRQ_ID_W = 5;

    typedef enum logic [1:0] {
        IRQ_ARB_IDLE,
        IRQ_ARB_REQ,
        IRQ_ARB_SVC
    } irq_arb_state_e;

    localparam logic [2:0] ADDR_ENABLE  = 3'd0;
    localparam logic [2:0] ADDR_SECURE  = 3'd1;
    localparam logic [2:0] ADDR_PENDING = 3'd2;
    localparam logic [2:0] ADDR_CLAIM   = 3'd3;
    localparam logic [2:0] ADDR_EDGE    = 3'd4;

    function automatic logic [31:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
        return 32'd1 << id;
    endfunction

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Lowest-index-first priority encoder: request vector -> {valid, id}.
module riscv_irq_prio_enc
    import riscv_irq_pkg::*;
#(
    parameter int NUM_SRC = 32
) (
    input  logic [NUM_SRC-1:0]  req,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] id
);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[k]) begin
                valid = 1'b1;
                id    = IRQ_ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Interrupt source arbiter feeding the core interrupt controller.
// Optional edge-triggered sources are built when RISCV_IRQ_ARB_EDGE_EN is defined.
//
// state         | meaning
// IRQ_ARB_IDLE  | no request outstanding, arbitrating pending sources
// IRQ_ARB_REQ   | irq_o raised, waiting for controller ack or kill
// IRQ_ARB_SVC   | interrupt in service, waiting for software COMPLETE
module riscv_irq_arbiter
    import riscv_irq_pkg::*;
#(
    parameter int NUM_SRC = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_SRC-1:0]  irq_src_i,
    output logic                irq_o,
    output logic                irq_sec_o,
    output logic [IRQ_ID_W-1:0] irq_id_o,
    input  logic                irq_ack_i,
    input  logic                irq_kill_i,
    input  logic                cfg_req_i,
    input  logic                cfg_we_i,
    input  logic [2:0]          cfg_addr_i,
    input  logic [31:0]         cfg_wdata_i,
    output logic [31:0]         cfg_rdata_o
);

    irq_arb_state_e state, state_nxt;

    logic [NUM_SRC-1:0]  en;
    logic [NUM_SRC-1:0]  sec;
    logic [NUM_SRC-1:0]  pend;
    logic [NUM_SRC-1:0]  pend_nxt;
    logic [NUM_SRC-1:0]  grant_mask;
    logic [NUM_SRC-1:0]  pick_mask;
    logic [31:0]         grant_full;
    logic [31:0]         pick_full;
    logic                enc_valid;
    logic [IRQ_ID_W-1:0] enc_id;
    logic [IRQ_ID_W-1:0] svc_id;
    logic                wr;
    logic                rd;
    logic                complete;
    logic [31:0]         rd_mux;

    assign wr         = cfg_req_i & cfg_we_i;
    assign rd         = cfg_req_i & ~cfg_we_i;
    assign grant_full = id_onehot(irq_id_o);
    assign pick_full  = id_onehot(enc_id);
    assign grant_mask = grant_full[NUM_SRC-1:0];
    assign pick_mask  = pick_full[NUM_SRC-1:0];
    assign complete   = wr && (cfg_addr_i == ADDR_CLAIM) && (state == IRQ_ARB_SVC)
                        && (cfg_wdata_i[IRQ_ID_W-1:0] == svc_id);
    assign irq_o      = (state == IRQ_ARB_REQ);

`ifdef RISCV_IRQ_ARB_EDGE_EN
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_clr;

    assign rise     = irq_src_i & ~src_q & en;
    assign ack_clr  = ((state == IRQ_ARB_REQ) && irq_ack_i) ? grant_mask : '0;
    // a fresh edge outranks the ack clear landing in the same cycle
    assign pend_nxt = (edge_mode & (rise | (pend & ~ack_clr)))
                    | (~edge_mode & irq_src_i & en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_mode <= '0;
            src_q     <= '0;
        end else begin
            src_q <= irq_src_i;
            if (wr && (cfg_addr_i == ADDR_EDGE))
                edge_mode <= cfg_wdata_i[NUM_SRC-1:0];
        end
    end
`else
    assign pend_nxt = irq_src_i & en;
`endif

    // Arbitration only runs in IDLE, where nothing is in service, so the
    // in-service exclusion never removes a candidate.
    riscv_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .req   (pend),
        .valid (enc_valid),
        .id    (enc_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en   <= '0;
            sec  <= '0;
            pend <= '0;
        end else begin
            if (wr && (cfg_addr_i == ADDR_ENABLE))
                en <= cfg_wdata_i[NUM_SRC-1:0];
            if (wr && (cfg_addr_i == ADDR_SECURE))
                sec <= cfg_wdata_i[NUM_SRC-1:0];
            pend <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IRQ_ARB_IDLE: if (enc_valid) state_nxt = IRQ_ARB_REQ;
            IRQ_ARB_REQ: begin
                if (irq_ack_i)       state_nxt = IRQ_ARB_SVC;
                else if (irq_kill_i) state_nxt = IRQ_ARB_IDLE;
            end
            IRQ_ARB_SVC:  if (complete) state_nxt = IRQ_ARB_IDLE;
            default:      state_nxt = IRQ_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IRQ_ARB_IDLE;
            irq_id_o  <= '0;
            irq_sec_o <= 1'b0;
            svc_id    <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IRQ_ARB_IDLE) && enc_valid) begin
                irq_id_o  <= enc_id;
                irq_sec_o <= |(sec & pick_mask);
            end
            if ((state == IRQ_ARB_REQ) && irq_ack_i)
                svc_id <= irq_id_o;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (cfg_addr_i)
            ADDR_ENABLE:  rd_mux[NUM_SRC-1:0] = en;
            ADDR_SECURE:  rd_mux[NUM_SRC-1:0] = sec;
            ADDR_PENDING: rd_mux[NUM_SRC-1:0] = pend;
            ADDR_CLAIM:   if (state == IRQ_ARB_SVC) rd_mux[IRQ_ID_W-1:0] = svc_id;
`ifdef RISCV_IRQ_ARB_EDGE_EN
            ADDR_EDGE:    rd_mux[NUM_SRC-1:0] = edge_mode;
`endif
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  cfg_rdata_o <= '0;
        else if (rd) cfg_rdata_o <= rd_mux;
    end

endmodule
